// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB types and the decoder address map.
//   htrans_t    - AHB transfer type encoding
//   RESP_*      - HRESP encodings
//   ds_state_t  - default-slave FSM states
//   to_state_t  - wait-state timeout response states (used with AHB_DEC_TIMEOUT_EN)
//   SLV_BASE/SLV_MASK - per-slave address match (HADDR & MASK) == BASE
package ahb_pkg;

  localparam int unsigned MAP_ADDR_W = 32;
  localparam int unsigned MAP_SLAVES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  typedef enum logic [1:0] {
    TO_IDLE,
    TO_ERR1,
    TO_ERR2
  } to_state_t;

  localparam logic [MAP_ADDR_W-1:0] SLV_BASE [MAP_SLAVES] = '{
    32'h0000_0000, 32'h2000_0000, 32'h4000_0000
  };
  localparam logic [MAP_ADDR_W-1:0] SLV_MASK [MAP_SLAVES] = '{
    32'hF000_0000, 32'hF000_0000, 32'hF000_0000
  };

  // NONSEQ and SEQ are the only transfer types that need a real response.
  function automatic logic is_active(input htrans_t t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_decoder_mux_if.sv
// ahb_decoder_mux_if: bus signals between arbiter, decoder/mux and slaves.
//   HADDR/HTRANS              - granted master's address phase
//   HSEL_S/HREADY_S           - decoder outputs to the slaves
//   HRDATA_S/HREADYOUT_S/HRESP_S - per-slave responses (slave i at bit/slice i)
//   HRDATA_OUT/HREADY_OUT/HRESP_OUT - muxed response back to the arbiter
// Modports: slave = the decoder/mux view, master = the arbiter/slave-side view.
interface ahb_decoder_mux_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 3
);

  logic [ADDR_WIDTH-1:0]            HADDR;
  logic [1:0]                       HTRANS;
  logic [NUM_SLAVES-1:0]            HSEL_S;
  logic                             HREADY_S;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S;
  logic [NUM_SLAVES-1:0]            HREADYOUT_S;
  logic [NUM_SLAVES-1:0]            HRESP_S;
  logic [DATA_WIDTH-1:0]            HRDATA_OUT;
  logic                             HREADY_OUT;
  logic                             HRESP_OUT;

  modport slave (
    input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HSEL_S, HREADY_S, HRDATA_OUT, HREADY_OUT, HRESP_OUT
  );

  modport master (
    output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HSEL_S, HREADY_S, HRDATA_OUT, HREADY_OUT, HRESP_OUT
  );

endinterface

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers unmapped transfers with the two-cycle AHB ERROR.
//   HCLK, HRESETn - clock, async active-low reset
//   sel           - address phase targets no mapped slave
//   HTRANS        - transfer type of the address phase
//   HREADY        - bus HREADY (address phase is sampled when 1)
//   HREADYOUT     - default slave ready (valid when it owns the data phase)
//   HRESP         - default slave response
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic    HCLK,
  input  logic    HRESETn,
  input  logic    sel,
  input  htrans_t HTRANS,
  input  logic    HREADY,
  output logic    HREADYOUT,
  output logic    HRESP
);

  ds_state_t state_q;
  logic      hreadyout_q;
  logic      hresp_q;
  logic      start_err;

  assign start_err = sel && HREADY && is_active(HTRANS);

  // State and outputs registered together so each state carries its own response.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= DS_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
    end else begin
      unique case (state_q)
        DS_IDLE: begin
          if (start_err) begin
            state_q     <= DS_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= RESP_ERROR;
          end
        end
        DS_ERR1: begin
          state_q     <= DS_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= RESP_ERROR;
        end
        DS_ERR2: begin
          // ERR2 completes with HREADY=1, so a new unmapped transfer is accepted here.
          if (start_err) begin
            state_q     <= DS_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= RESP_ERROR;
          end else begin
            state_q     <= DS_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
          end
        end
        default: begin
          state_q     <= DS_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= RESP_OKAY;
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: rtl/ahb_decoder_mux.sv
// ahb_decoder_mux: AHB address decoder and slave response multiplexer.
//   HCLK, HRESETn - clock, async active-low reset
//   bus (slave modport of ahb_decoder_mux_if):
//     HADDR/HTRANS in -> HSEL_S one-hot select (combinational, HTRANS-independent)
//     HREADY_S = HREADY_OUT broadcast to all slaves
//     HRDATA_S/HREADYOUT_S/HRESP_S in -> HRDATA_OUT/HREADY_OUT/HRESP_OUT from
//     the data-phase slave (or the built-in default slave for unmapped addresses)
// Optional feature: define AHB_DEC_TIMEOUT_EN to bound slave wait states to
// TIMEOUT_CYCLES, after which a two-cycle ERROR is forced.
module ahb_decoder_mux
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_decoder_mux_if.slave bus
);

  localparam int unsigned SEL_W = NUM_SLAVES + 1;
  localparam int unsigned DEF_IDX = NUM_SLAVES;

  logic [NUM_SLAVES-1:0] hsel_c;
  logic                  unmapped_c;
  logic [SEL_W-1:0]      sel_dp_d;
  logic [SEL_W-1:0]      sel_dp_q;
  logic                  ds_hreadyout;
  logic                  ds_hresp;
  logic [DATA_WIDTH-1:0] mux_rdata;
  logic                  mux_ready;
  logic                  mux_resp;
  logic [DATA_WIDTH-1:0] rdata_out;
  logic                  hready_out;
  logic                  hresp_out;

  // Address decode; iterating downward lets the lowest matching index win.
  always_comb begin
    hsel_c = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.HADDR & ADDR_WIDTH'(SLV_MASK[i])) == ADDR_WIDTH'(SLV_BASE[i])) begin
        hsel_c    = '0;
        hsel_c[i] = 1'b1;
      end
    end
  end

  assign unmapped_c = ~|hsel_c;

  // Data-phase select advances only when the current data phase completes.
  assign sel_dp_d = hready_out ? {unmapped_c, hsel_c} : sel_dp_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_dp_q          <= '0;
      sel_dp_q[DEF_IDX] <= 1'b1;
    end else begin
      sel_dp_q <= sel_dp_d;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (unmapped_c),
    .HTRANS    (htrans_t'(bus.HTRANS)),
    .HREADY    (hready_out),
    .HREADYOUT (ds_hreadyout),
    .HRESP     (ds_hresp)
  );

  // Response mux driven by the one-hot data-phase select.
  always_comb begin
    mux_rdata = '0;
    mux_ready = 1'b1;
    mux_resp  = RESP_OKAY;
    if (sel_dp_q[DEF_IDX]) begin
      mux_ready = ds_hreadyout;
      mux_resp  = ds_hresp;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_dp_q[i]) begin
        mux_rdata = bus.HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        mux_ready = bus.HREADYOUT_S[i];
        mux_resp  = bus.HRESP_S[i];
      end
    end
  end

`ifdef AHB_DEC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  to_state_t       to_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            mapped_dp;

  assign mapped_dp = |sel_dp_q[NUM_SLAVES-1:0];
  assign to_cnt_d  = to_cnt_q + TO_W'(1);

  // Counts stalled cycles of a mapped slave; expiry hands the bus an ERROR.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_q     <= TO_IDLE;
      to_cnt_q <= '0;
    end else begin
      unique case (to_q)
        TO_IDLE: begin
          if (mapped_dp && !mux_ready) begin
            if (to_cnt_d == TO_W'(TIMEOUT_CYCLES)) begin
              to_q     <= TO_ERR1;
              to_cnt_q <= '0;
            end else begin
              to_cnt_q <= to_cnt_d;
            end
          end else begin
            to_cnt_q <= '0;
          end
        end
        TO_ERR1: begin
          to_q     <= TO_ERR2;
          to_cnt_q <= '0;
        end
        default: begin
          to_q     <= TO_IDLE;
          to_cnt_q <= '0;
        end
      endcase
    end
  end

  // Forced ERROR overrides the stalled slave; its late response is dropped.
  always_comb begin
    rdata_out  = mux_rdata;
    hready_out = mux_ready;
    hresp_out  = mux_resp;
    if (to_q == TO_ERR1) begin
      rdata_out  = '0;
      hready_out = 1'b0;
      hresp_out  = RESP_ERROR;
    end else if (to_q == TO_ERR2) begin
      rdata_out  = '0;
      hready_out = 1'b1;
      hresp_out  = RESP_ERROR;
    end
  end
`else
  always_comb begin
    rdata_out  = mux_rdata;
    hready_out = mux_ready;
    hresp_out  = mux_resp;
  end
`endif

  assign bus.HSEL_S     = hsel_c;
  assign bus.HREADY_S   = hready_out;
  assign bus.HRDATA_OUT = rdata_out;
  assign bus.HREADY_OUT = hready_out;
  assign bus.HRESP_OUT  = hresp_out;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// tb_ahb_decoder_mux: directed-vector bench for ahb_decoder_mux.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
module tb_ahb_decoder_mux;
  import ahb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;
  localparam int unsigned TO = 8;

  localparam logic [DW-1:0] D0 = 32'h1111_0000;
  localparam logic [DW-1:0] D1 = 32'hCAFE_F00D;
  localparam logic [DW-1:0] D2 = 32'h2222_0000;

  logic HCLK;
  logic HRESETn;
  int   n_checks;
  int   n_pass;

  ahb_decoder_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

  ahb_decoder_mux #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  // Drive an address phase and let the combinational outputs settle.
  task automatic addr(input logic [AW-1:0] a, input htrans_t t);
    bus.HADDR  = a;
    bus.HTRANS = t;
    #1;
  endtask

  task automatic rsp(input string tag, input logic rdy, input logic err);
    check({tag, "_ready"}, 64'(bus.HREADY_OUT), 64'(rdy));
    check({tag, "_resp"},  64'(bus.HRESP_OUT),  64'(err));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    HRESETn  = 1'b0;
    bus.HADDR       = 32'h8000_0000;
    bus.HTRANS      = IDLE;
    bus.HRDATA_S    = {D2, D1, D0};
    bus.HREADYOUT_S = '1;
    bus.HRESP_S     = '0;

    // Reset held for three cycles
    repeat (3) tick();
    #1;
    rsp("rst", 1'b1, 1'b0);
    check("rst_rdata", 64'(bus.HRDATA_OUT), 64'h0);
    check("rst_hsel",  64'(bus.HSEL_S), 64'h0);
    check("rst_hready_s", 64'(bus.HREADY_S), 64'h1);
    HRESETn = 1'b1;
    tick();

    // Zero-wait read from S1
    addr(32'h2000_0010, NONSEQ);
    check("s1_hsel", 64'(bus.HSEL_S), 64'h2);
    tick();
    addr(32'h0000_0000, IDLE);
    check("s1_rdata", 64'(bus.HRDATA_OUT), 64'(D1));
    rsp("s1", 1'b1, 1'b0);
    check("s0_hsel", 64'(bus.HSEL_S), 64'h1);
    tick();

    // Unmapped NONSEQ -> ERR1, ERR2, then idle; unmapped IDLE gets OKAY
    addr(32'h8000_0000, NONSEQ);
    check("um_hsel", 64'(bus.HSEL_S), 64'h0);
    tick();
    addr(32'h8000_0000, IDLE);
    rsp("um_err1", 1'b0, 1'b1);
    check("um_rdata", 64'(bus.HRDATA_OUT), 64'h0);
    tick();
    rsp("um_err2", 1'b1, 1'b1);
    tick();
    rsp("um_idle", 1'b1, 1'b0);
    tick();
    rsp("um_idle2", 1'b1, 1'b0);

    // S0 with three wait states; the next S2 address phase is held
    bus.HREADYOUT_S[0] = 1'b0;
    addr(32'h0000_0004, NONSEQ);
    tick();
    addr(32'h4000_0000, NONSEQ);
    check("ws_hsel", 64'(bus.HSEL_S), 64'h4);
    for (int i = 0; i < 3; i++) begin
      #1;
      rsp($sformatf("ws%0d", i), 1'b0, 1'b0);
      check($sformatf("ws%0d_rdata", i), 64'(bus.HRDATA_OUT), 64'(D0));
      tick();
    end
    bus.HREADYOUT_S[0] = 1'b1;
    #1;
    rsp("ws_done", 1'b1, 1'b0);
    check("ws_done_rdata", 64'(bus.HRDATA_OUT), 64'(D0));
    tick();
    addr(32'h0000_0000, IDLE);
    check("ws_s2_rdata", 64'(bus.HRDATA_OUT), 64'(D2));
    tick();

    // Pipelined mapped -> unmapped -> mapped
    addr(32'h0000_0000, NONSEQ);
    tick();
    addr(32'h9000_0000, NONSEQ);
    rsp("pl_ok", 1'b1, 1'b0);
    check("pl_ok_rdata", 64'(bus.HRDATA_OUT), 64'(D0));
    tick();
    addr(32'h2000_0000, NONSEQ);
    rsp("pl_err1", 1'b0, 1'b1);
    tick();
    rsp("pl_err2", 1'b1, 1'b1);
    check("pl_err2_hsel", 64'(bus.HSEL_S), 64'h2);
    tick();
    addr(32'h0000_0000, IDLE);
    rsp("pl_s1", 1'b1, 1'b0);
    check("pl_s1_rdata", 64'(bus.HRDATA_OUT), 64'(D1));
    tick();

    // Back-to-back unmapped transfers chain ERR2 -> ERR1
    addr(32'h8000_0000, NONSEQ);
    tick();
    rsp("bb_err1a", 1'b0, 1'b1);
    tick();
    addr(32'hA000_0000, NONSEQ);
    rsp("bb_err2a", 1'b1, 1'b1);
    tick();
    addr(32'h0000_0000, IDLE);
    rsp("bb_err1b", 1'b0, 1'b1);
    tick();
    rsp("bb_err2b", 1'b1, 1'b1);
    tick();
    rsp("bb_idle", 1'b1, 1'b0);

    // Slave ERROR passes through; async reset mid-stall restores idle outputs
    addr(32'h4000_0000, NONSEQ);
    tick();
    addr(32'h0000_0000, IDLE);
    bus.HRESP_S[2] = 1'b1;
    bus.HREADYOUT_S[2] = 1'b0;
    #1;
    rsp("s2_err", 1'b0, 1'b1);
    HRESETn = 1'b0;
    #1;
    rsp("mid_rst", 1'b1, 1'b0);
    check("mid_rst_rdata", 64'(bus.HRDATA_OUT), 64'h0);
    bus.HRESP_S[2] = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();

`ifdef AHB_DEC_TIMEOUT_EN
    // Stalled S2 times out after TO wait cycles
    addr(32'h4000_0000, NONSEQ);
    tick();
    addr(32'h0000_0000, IDLE);
    for (int i = 0; i < int'(TO); i++) begin
      rsp($sformatf("to_wait%0d", i), 1'b0, 1'b0);
      tick();
    end
    rsp("to_err1", 1'b0, 1'b1);
    check("to_err1_rdata", 64'(bus.HRDATA_OUT), 64'h0);
    tick();
    rsp("to_err2", 1'b1, 1'b1);
    tick();
    rsp("to_after", 1'b1, 1'b0);

    // Reset pulse mid-wait clears the count
    addr(32'h4000_0000, NONSEQ);
    tick();
    addr(32'h0000_0000, IDLE);
    repeat (5) tick();
    HRESETn = 1'b0;
    #1;
    HRESETn = 1'b1;
    tick();
    addr(32'h4000_0000, NONSEQ);
    tick();
    addr(32'h0000_0000, IDLE);
    for (int i = 0; i < int'(TO); i++) begin
      rsp($sformatf("to_rw%0d", i), 1'b0, 1'b0);
      tick();
    end
    rsp("to_rerr1", 1'b0, 1'b1);
    tick();
    tick();
    bus.HREADYOUT_S[2] = 1'b1;
`endif

    bus.HREADYOUT_S[2] = 1'b1;
    #1;
    rsp("final", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
